// File: rtl/snap_pkg.sv
// snap_pkg: shared widths and capture state type for the snapshot write controller
package snap_pkg;
  localparam int SNAP_DATA_W = 64;
  localparam int SNAP_ADDR_W = 9;
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} snap_state_t;
endpackage

// File: rtl/snap_wr_ptr.sv
// snap_wr_ptr: BRAM write pointer (wrapping or parking at the top) plus saturating word count
module snap_wr_ptr import snap_pkg::*; #(
  parameter int ADDR_W = SNAP_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  input  logic              wrap_en,
  output logic [ADDR_W-1:0] ptr,
  output logic [ADDR_W:0]   count
);
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  // clear wins over increment; the count stops at exactly one buffer depth
  always_comb begin
    ptr_d = clr ? '0 : (inc && (wrap_en || ~&ptr_q)) ? ptr_q + ADDR_W'(1) : ptr_q;
    cnt_d = clr ? '0 : (inc && !cnt_q[ADDR_W]) ? cnt_q + (ADDR_W+1)'(1) : cnt_q;
  end
  // pointer and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
  assign ptr   = ptr_q;
  assign count = cnt_q;
endmodule

// File: rtl/snap_capture_ctrl.sv
// snap_capture_ctrl: snapshot BRAM port-A write controller; SNAP_CIRC_EN enables pre-trigger circular capture
module snap_capture_ctrl import snap_pkg::*; #(
  parameter int DATA_W = SNAP_DATA_W,
  parameter int ADDR_W = SNAP_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              arm,
  input  logic              use_trig,
  input  logic              trig,
  input  logic [ADDR_W-1:0] post_trig,
  output logic              bram_we,
  output logic              bram_en_a,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wr_data,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W:0]   wr_count,
  output logic [ADDR_W-1:0] trig_addr
);
`ifdef SNAP_CIRC_EN
  localparam logic CIRC = 1'b1;
`else
  localparam logic CIRC = 1'b0;
`endif
  snap_state_t       state_q, state_d;
  logic              arm_q, arm_rise, is_trig, accept, fin;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d, trig_addr_q, trig_addr_d, last_q, last_d, trig_last, ptr;
  logic [DATA_W-1:0] data_q, data_d;
  snap_wr_ptr #(.ADDR_W(ADDR_W)) u_ptr (
    .clk(clk), .rst_n(rst_n), .clr(arm_rise), .inc(accept), .wrap_en(CIRC),
    .ptr(ptr), .count(wr_count)
  );
  // the final write is the one landing on last_q; a trigger re-targets it to trig_ptr+post_trig-1
  // (post_trig=0 folds naturally to a full buffer); an arm edge overrides everything but the write itself
  always_comb begin
    arm_rise    = arm & ~arm_q;
    is_trig     = state_q == ARMED && din_valid && trig;
    accept      = din_valid && (state_q == CAPTURE || (state_q == ARMED && (trig || CIRC)));
    trig_last   = CIRC ? ptr + post_trig - ADDR_W'(1) : '1;
    fin         = accept && (state_q == CAPTURE ? ptr == last_q : is_trig && ptr == trig_last);
    state_d     = arm_rise ? (use_trig ? ARMED : CAPTURE) : fin ? DONE : is_trig ? CAPTURE : state_q;
    trig_addr_d = arm_rise ? '0 : (CIRC && is_trig) ? ptr : trig_addr_q;
    last_d      = arm_rise ? '1 : is_trig ? trig_last : last_q;
    we_d        = accept;
    addr_d      = accept ? ptr : addr_q;
    data_d      = accept ? din : data_q;
  end
  // state, arm edge detector and registered port-A write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      arm_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      trig_addr_q <= '0;
      last_q      <= '1;
    end else begin
      state_q     <= state_d;
      arm_q       <= arm;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      trig_addr_q <= trig_addr_d;
      last_q      <= last_d;
    end
  end
  assign bram_we      = we_q;
  assign bram_en_a    = we_q;
  assign bram_addr    = addr_q;
  assign bram_wr_data = data_q;
  assign done         = state_q == DONE;
  assign busy         = state_q == ARMED || state_q == CAPTURE;
  assign trig_addr    = trig_addr_q;
endmodule

// File: tb/tb_snap_capture_ctrl.sv
// tb_snap_capture_ctrl: scoreboard bench with a capture-level reference model
module tb_snap_capture_ctrl;
  localparam int DEPTH = 512;
`ifdef SNAP_CIRC_EN
  localparam bit CIRC = 1'b1;
`else
  localparam bit CIRC = 1'b0;
`endif
  typedef struct packed {logic [8:0] a; logic [63:0] d;} wr_t;
  logic        clk = 1'b0, rst_n = 1'b0, din_valid = 1'b0, arm = 1'b0, use_trig = 1'b0, trig = 1'b0;
  logic [63:0] din = '0;
  logic [8:0]  post_trig = '0;
  logic        bram_we, bram_en_a, done, busy;
  logic [8:0]  bram_addr, trig_addr;
  logic [63:0] bram_wr_data;
  logic [9:0]  wr_count;
  wr_t         exp_q[$];
  wr_t         e, last_wr;
  int          errors = 0, checks = 0;
  int          ph, m_addr, m_cnt, m_rem, m_trig, sidx;
  bit          m_arm_q, rise, wr, use_idx;

  always #5 clk = ~clk;

  snap_capture_ctrl dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .arm(arm),
    .use_trig(use_trig), .trig(trig), .post_trig(post_trig),
    .bram_we(bram_we), .bram_en_a(bram_en_a), .bram_addr(bram_addr),
    .bram_wr_data(bram_wr_data), .done(done), .busy(busy),
    .wr_count(wr_count), .trig_addr(trig_addr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: phase 0 idle, 1 waiting for trigger, 2 capturing, 3 finished
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      ph = 0; m_addr = 0; m_cnt = 0; m_rem = 0; m_trig = 0; m_arm_q = 0;
      exp_q.delete();
    end else begin
      rise = arm && !m_arm_q;
      m_arm_q = arm;
      wr = 0;
      if (ph == 1 && din_valid) begin
        if (trig) begin
          ph = 2;
          m_rem = (CIRC && post_trig != 0) ? int'(post_trig) : DEPTH;
          if (CIRC) m_trig = m_addr;
        end
        wr = trig || CIRC;
      end else if (ph == 2 && din_valid) wr = 1;
      if (wr) begin
        exp_q.push_back(wr_t'{a: m_addr[8:0], d: din});
        m_addr = (m_addr + 1) % DEPTH;
        if (m_cnt < DEPTH) m_cnt++;
        if (ph == 2) begin
          m_rem--;
          if (m_rem == 0) ph = 3;
        end
      end
      if (rise) begin
        ph = use_trig ? 1 : 2; m_addr = 0; m_cnt = 0; m_trig = 0; m_rem = DEPTH;
      end
    end
  end

  // monitor: pop the scoreboard whenever a write is due and check status every cycle
  initial forever begin
    @(negedge clk);
    if (!rst_n) last_wr = '0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("we", bram_we, 1);
      chk("en_a", bram_en_a, 1);
      chk("addr", bram_addr, e.a);
      chk("data", bram_wr_data, e.d);
      last_wr = e;
    end else begin
      chk("we_idle", bram_we, 0);
      chk("en_a_idle", bram_en_a, 0);
      chk("addr_hold", bram_addr, last_wr.a);
      chk("data_hold", bram_wr_data, last_wr.d);
    end
    chk("done", done, ph == 3);
    chk("busy", busy, ph == 1 || ph == 2);
    chk("wr_count", wr_count, m_cnt);
    chk("trig_addr", trig_addr, m_trig);
  end

  task automatic step(input logic v, input logic t, input logic a);
    @(negedge clk);
    #1;
    din_valid = v; trig = t; arm = a;
    din = (use_idx && v) ? 64'(sidx) : {$urandom, $urandom};
    if (v) sidx++;
  endtask

  initial begin
    use_idx = 1;
    repeat (3) step(0, 0, 0);
    rst_n = 1'b1;
    // reset in the middle of a capture
    use_trig = 0; step(0, 0, 1); sidx = 0;
    repeat (101) step(1, 0, 1);
    @(negedge clk); #2;
    rst_n = 1'b0; arm = 0; din_valid = 0;
    #1;
    chk("rst_we", bram_we, 0); chk("rst_en", bram_en_a, 0); chk("rst_addr", bram_addr, 0);
    chk("rst_data", bram_wr_data, 0); chk("rst_done", done, 0); chk("rst_busy", busy, 0);
    chk("rst_cnt", wr_count, 0); chk("rst_trig", trig_addr, 0);
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (5) step(0, 0, 0);
    chk("idle_busy", busy, 0);
    // linear, immediate capture, continuous valid
    step(0, 0, 1); sidx = 0;
    repeat (520) step(1, 0, 1);
    @(negedge clk); #2;
    chk("t1_done", done, 1); chk("t1_cnt", wr_count, 512); chk("t1_last", last_wr.a, 511);
    // one valid every third cycle
    step(0, 0, 0); step(0, 0, 1); sidx = 0;
    for (int i = 0; i < 1600; i++) step(i % 3 == 0, 0, 1);
    @(negedge clk); #2;
    chk("t2_done", done, 1); chk("t2_cnt", wr_count, 512);
    // triggered capture, trig on sample 7, ignored trig pulses without valid
    use_trig = 1; step(0, 0, 0); step(0, 0, 1); sidx = 0;
    repeat (4) step(0, 1, 1);
    chk("t3_armed", busy, 1); chk("t3_cnt0", wr_count, 0);
    for (int i = 0; i < 530; i++) step(1, i == 7, 1);
    @(negedge clk); #2;
    chk("t3_done", done, 1); chk("t3_last_data", last_wr.d, 518);
    // re-arm at wr_count = 100
    use_trig = 0; step(0, 0, 0); step(0, 0, 1); sidx = 0;
    repeat (100) step(1, 0, 1);
    step(0, 0, 0); step(0, 0, 1);
    @(negedge clk); #2;
    chk("t4_cnt0", wr_count, 0); chk("t4_done0", done, 0);
    sidx = 0;
    repeat (520) step(1, 0, 1);
    @(negedge clk); #2;
    chk("t4_done", done, 1);
`ifdef SNAP_CIRC_EN
    // circular: trigger at pointer 300, 256 post-trigger samples
    use_trig = 1; post_trig = 9'd256; step(0, 0, 0); step(0, 0, 1); sidx = 0;
    repeat (300) step(1, 0, 1);
    step(1, 1, 1);
    repeat (300) step(1, 0, 1);
    @(negedge clk); #2;
    chk("c_trig_addr", trig_addr, 300); chk("c_last", last_wr.a, 43);
    chk("c_done", done, 1); chk("c_cnt", wr_count, 512);
`endif
    // randomized traffic
    use_idx = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) use_trig = $urandom_range(0, 1);
      post_trig = 9'($urandom);
      step($urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0,
           ($urandom_range(0, 199) == 0) ? ~arm : arm);
    end
    repeat (3) step(0, 0, arm);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
